// File: rtl/carrier_gen_multich_pkg.sv
// Shared PWM carrier types: count/mask modes, enables, carrier direction.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

  typedef enum logic [1:0] {
    COUNT_UP     = 2'd0,
    COUNT_DOWN   = 2'd1,
    COUNT_UPDOWN = 2'd2
  } _count_mode;

  typedef enum logic [1:0] {
    NO_MASK     = 2'd0,
    MIN_MASK    = 2'd1,
    MAX_MASK    = 2'd2,
    MINMAX_MASK = 2'd3
  } _mask_mode;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic {
    CARR_OFF = 1'b0,
    CARR_ON  = 1'b1
  } _carr_onoff;

  typedef enum bit {
    CARR_UP   = 1'b0,
    CARR_DOWN = 1'b1
  } _carr_dir;

endpackage

// File: rtl/carrier_gen_multich_chan.sv
// One carrier channel: counter, direction and registered mask strobe.
module carrier_chan
  import PKG_pwm::*;
#(
  parameter int unsigned WIDTH = `PWMCOUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_i,
  input  logic             run_i,
  input  logic             load_all_i,
  input  logic [WIDTH-1:0] phase_i,
  input  logic [WIDTH-1:0] period_i,
  input  _carr_dir         phase_dir_i,
  input  _count_mode       count_mode_i,
  input  _mask_mode        mask_mode_i,
  output logic [WIDTH-1:0] carrier_o,
  output _carr_dir         dir_o,
  output logic             maskevent_o,
  output logic             wrap_c_o
);

  logic [WIDTH-1:0] carrier_q, carrier_d;
  logic [WIDTH-1:0] phase_q;
  _carr_dir         dir_q, dir_d;
  logic             mask_q, mask_d;
  logic             load_c;
  logic             at_min_c, at_max_c;

  always_comb begin
    carrier_d = carrier_q;
    dir_d     = dir_q;
    mask_d    = 1'b0;
    load_c    = load_all_i || (phase_i != phase_q);
    at_min_c  = (carrier_q == '0);
    at_max_c  = (carrier_q == period_i);

    if (!active_i) begin
      carrier_d = '0;
      dir_d     = CARR_UP;
    end else begin
      // Strobe reflects the carrier value held during this cycle
      unique case (mask_mode_i)
        NO_MASK:     mask_d = run_i;
        MIN_MASK:    mask_d = run_i && at_min_c;
        MAX_MASK:    mask_d = run_i && at_max_c;
        MINMAX_MASK: mask_d = run_i && (at_min_c || at_max_c);
        default:     mask_d = 1'b0;
      endcase

      if (load_c) begin
        carrier_d = (phase_i > period_i) ? period_i : phase_i;
        case (count_mode_i)
          COUNT_DOWN:   dir_d = CARR_DOWN;
          COUNT_UPDOWN: dir_d = phase_dir_i;
          default:      dir_d = CARR_UP;
        endcase
      end else if (carrier_q > period_i) begin
        // Period shrank under us: clamp instead of wrapping the full range
        carrier_d = period_i;
        dir_d     = (count_mode_i == COUNT_UP) ? CARR_UP : CARR_DOWN;
      end else begin
        case (count_mode_i)
          COUNT_UP: begin
            dir_d     = CARR_UP;
            carrier_d = at_max_c ? '0 : carrier_q + WIDTH'(1);
          end
          COUNT_DOWN: begin
            dir_d     = CARR_DOWN;
            carrier_d = at_min_c ? period_i : carrier_q - WIDTH'(1);
          end
          COUNT_UPDOWN: begin
            if (dir_q == CARR_UP) begin
              if (at_max_c) begin
                carrier_d = (period_i != '0) ? period_i - WIDTH'(1) : '0;
                dir_d     = CARR_DOWN;
              end else begin
                carrier_d = carrier_q + WIDTH'(1);
              end
            end else begin
              if (at_min_c) begin
                carrier_d = WIDTH'(1);
                dir_d     = CARR_UP;
              end else begin
                carrier_d = carrier_q - WIDTH'(1);
              end
            end
          end
          default: carrier_d = carrier_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carrier_q <= '0;
      dir_q     <= CARR_UP;
      mask_q    <= 1'b0;
      phase_q   <= '0;
    end else begin
      carrier_q <= carrier_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      phase_q   <= phase_i;
    end
  end

  assign carrier_o   = carrier_q;
  assign dir_o       = dir_q;
  assign maskevent_o = mask_q;
  assign wrap_c_o    = (carrier_d == '0);

endmodule

// File: rtl/carrier_gen_multich.sv
// Multi-channel phase-shifted PWM carrier generator with shadowed period and resync.
module carrier_gen_multich
  import PKG_pwm::*;
#(
  parameter int unsigned WIDTH = `PWMCOUNT_WIDTH,
  parameter int unsigned NCH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     period,
  input  logic [NCH*WIDTH-1:0] phase,
  input  logic [NCH-1:0]       phase_dir,
  input  _count_mode           count_mode,
  input  _mask_mode            mask_mode,
  input  _pwm_onoff            pwm_onoff,
  input  _carr_onoff           carr_onoff,
  input  logic                 sync_in,
  output logic [NCH*WIDTH-1:0] carrier,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       maskevent,
  output logic [WIDTH-1:0]     period_act
);

  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic             en_q, run_q, sync_q;
  logic             on_c, en_c, active_c, load_all_c, ch0_upd_c;
  logic [NCH-1:0]   wrap;

  always_comb begin
    on_c         = (pwm_onoff == PWM_ON) && (carr_onoff == CARR_ON);
    en_c         = on_c && (period_act_q != '0);
    active_c     = en_c && en_q;
    load_all_c   = active_c && (!run_q || sync_q);
    // Channel 0 is the reference for the shadow period update point
    ch0_upd_c    = |(wrap & NCH'(1));
    period_act_d = period_act_q;
    if (!(on_c && (period != '0)) || ch0_upd_c) begin
      period_act_d = period;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_act_q <= '0;
      en_q         <= 1'b0;
      run_q        <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      period_act_q <= period_act_d;
      en_q         <= en_c;
      run_q        <= active_c;
      sync_q       <= sync_in;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    _carr_dir dir_ch;

    carrier_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .active_i     (active_c),
      .run_i        (run_q),
      .load_all_i   (load_all_c),
      .phase_i      (phase[g*WIDTH +: WIDTH]),
      .period_i     (period_act_q),
      .phase_dir_i  (_carr_dir'(phase_dir[g])),
      .count_mode_i (count_mode),
      .mask_mode_i  (mask_mode),
      .carrier_o    (carrier[g*WIDTH +: WIDTH]),
      .dir_o        (dir_ch),
      .maskevent_o  (maskevent[g]),
      .wrap_c_o     (wrap[g])
    );

    assign dir[g] = dir_ch;
  end

  assign period_act = period_act_q;

endmodule
